// File: rtl/mult_share_arbiter.sv
// Two-requester front end for one shared unsigned WIDTH x WIDTH multiplier.
// It does round-robin grant, operand capture, fixed-latency sequencing and a valid/ready result port.
module mult_share_arbiter #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               gnt0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_data,
  output logic               busy,
  output logic [15:0]        op_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_t             state_reg, state_next;
  logic               rr_ptr_reg, rr_ptr_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [WIDTH-1:0]   a_reg, a_next, b_reg, b_next;
  logic               id_reg, id_next;
  logic [1:0]         gnt_reg, gnt_next;
  logic               valid_reg, valid_next;
  logic               res_id_reg, res_id_next;
  logic [2*WIDTH-1:0] res_data_reg, res_data_next;
  logic [15:0]        op_count_reg, op_count_next;
  logic               winner;
  logic [2*WIDTH-1:0] product;

  // A lone requester always wins; rr_ptr only breaks ties.
  assign winner  = (req0 & req1) ? rr_ptr_reg : req1;
  assign product = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= 1'b0;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      id_reg       <= 1'b0;
      gnt_reg      <= 2'b00;
      valid_reg    <= 1'b0;
      res_id_reg   <= 1'b0;
      res_data_reg <= '0;
      op_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      cnt_reg      <= cnt_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      id_reg       <= id_next;
      gnt_reg      <= gnt_next;
      valid_reg    <= valid_next;
      res_id_reg   <= res_id_next;
      res_data_reg <= res_data_next;
      op_count_reg <= op_count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    cnt_next      = cnt_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    id_next       = id_reg;
    gnt_next      = 2'b00;
    valid_next    = valid_reg;
    res_id_next   = res_id_reg;
    res_data_next = res_data_reg;
    op_count_next = op_count_reg;
    case (state_reg)
      IDLE: begin
        if (req0 | req1) begin
          a_next      = winner ? a1 : a0;
          b_next      = winner ? b1 : b0;
          id_next     = winner;
          cnt_next    = CNT_INIT;
          gnt_next    = winner ? 2'b10 : 2'b01;
          rr_ptr_next = ~winner;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          res_data_next = product;
          res_id_next   = id_reg;
          valid_next    = 1'b1;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        // Result is held until the consumer takes it; no requests are sampled here.
        if (res_ready) begin
          valid_next    = 1'b0;
          op_count_next = op_count_reg + 16'd1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign res_valid = valid_reg;
  assign res_id    = res_id_reg;
  assign res_data  = res_data_reg;
  assign busy      = (state_reg != IDLE);
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: hand-computed products, grant order,
// stall behaviour, mid-operation reset and op_count wrap.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, gnt0, gnt1;
  logic [7:0]  a0, b0, a1, b1;
  logic        res_valid, res_ready, res_id, busy;
  logic [15:0] res_data, op_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  t3_a  [4] = '{8'd3, 8'd5, 8'd7, 8'd9};
  logic [7:0]  t3_b  [4] = '{8'd4, 8'd6, 8'd8, 8'd10};
  logic [15:0] t3_p  [4] = '{16'd12, 16'd30, 16'd56, 16'd90};
  logic        t3_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  mult_share_arbiter #(.WIDTH(8), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   {30'd0, gnt1, gnt0}, 32'd0);
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_id"},    {31'd0, res_id}, 32'd0);
    check({tag, "_data"},  {16'd0, res_data}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_count"}, {16'd0, op_count}, 32'd0);
  endtask

  // One isolated request from a single requester, accepted immediately.
  task automatic single_op(input string tag, input logic which, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp_data,
                           input logic [15:0] exp_count);
    res_ready = 1'b1;
    if (which) begin req1 = 1'b1; a1 = a; b1 = b; end
    else       begin req0 = 1'b1; a0 = a; b0 = b; end
    step();
    check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, which ? 32'd2 : 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    check({tag, "_res"}, {14'd0, res_valid, res_id, res_data}, {14'd0, 1'b1, which, exp_data});
    step();
    check({tag, "_done"}, {15'd0, res_valid, op_count}, {15'd0, 1'b0, exp_count});
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // 12 * 13 with latency tracking
    req0 = 1'b1; a0 = 8'd12; b0 = 8'd13; res_ready = 1'b1;
    step();
    check("t1_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    step();
    check("t1_wait", {29'd0, gnt1, gnt0, res_valid}, 32'd0);
    step();
    check("t1_res", {14'd0, res_valid, res_id, res_data}, {14'd0, 1'b1, 1'b0, 16'd156});
    step();
    check("t1_done", {14'd0, res_valid, busy, op_count}, {14'd0, 1'b0, 1'b0, 16'd1});

    // Extremes
    single_op("t2_zero", 1'b0, 8'h00, 8'hFF, 16'h0000, 16'd2);
    single_op("t2_max",  1'b1, 8'hFF, 8'hFF, 16'hFE01, 16'd3);

    // Both requesting continuously: grants alternate starting at 0
    res_ready = 1'b1;
    req0 = 1'b1; a0 = t3_a[0]; b0 = t3_b[0];
    req1 = 1'b1; a1 = t3_a[1]; b1 = t3_b[1];
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t3_gnt%0d", i), {30'd0, gnt1, gnt0}, t3_id[i] ? 32'd2 : 32'd1);
      if (i + 2 < 4) begin
        if (t3_id[i]) begin a1 = t3_a[i+2]; b1 = t3_b[i+2]; end
        else          begin a0 = t3_a[i+2]; b0 = t3_b[i+2]; end
      end
      step();
      step();
      check($sformatf("t3_res%0d", i), {14'd0, res_valid, res_id, res_data},
            {14'd0, 1'b1, t3_id[i], t3_p[i]});
      step();
      check($sformatf("t3_done%0d", i), {15'd0, res_valid, op_count},
            {15'd0, 1'b0, 16'(4 + i)});
    end
    req0 = 1'b0; req1 = 1'b0;

    // Consumer stall for 10 cycles with req0 held
    res_ready = 1'b0;
    req0 = 1'b1; a0 = 8'd20; b0 = 8'd11;
    step();
    check("t4_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    step();
    step();
    check("t4_res", {14'd0, res_valid, res_id, res_data}, {14'd0, 1'b1, 1'b0, 16'h00DC});
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t4_stall%0d", k), {12'd0, res_valid, res_id, res_data, gnt1, gnt0, busy},
            {12'd0, 1'b1, 1'b0, 16'h00DC, 2'b00, 1'b1});
    end
    req0 = 1'b0;
    res_ready = 1'b1;
    step();
    check("t4_done", {15'd0, res_valid, op_count}, {15'd0, 1'b0, 16'd8});

    // Reset during BUSY; rr_ptr was 1 so requester 1 wins first
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
    req1 = 1'b1; a1 = 8'd4; b1 = 8'd5;
    step();
    check("t5_gnt_pre", {30'd0, gnt1, gnt0}, 32'd2);
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    step();
    check("t5_gnt_post", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("t5_novalid", {31'd0, res_valid}, 32'd0);
    step();
    check("t5_res", {14'd0, res_valid, res_id, res_data}, {14'd0, 1'b1, 1'b0, 16'd6});
    step();
    check("t5_done", {15'd0, res_valid, op_count}, {15'd0, 1'b0, 16'd1});

    // op_count wrap
    force dut.op_count_reg = 16'hFFFF;
    step();
    release dut.op_count_reg;
    step();
    check("t6_preload", {16'd0, op_count}, 32'h0000FFFF);
    single_op("t6_wrap", 1'b1, 8'h10, 8'h10, 16'h0100, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
